bcd_score_counter_n: RTL and testbench
======================================

Name: bcd_score_counter_n

Overview:
Parametrised multi-digit BCD counter for score and game-time display. It accepts multi-digit BCD additions and single-step decrements. Digit 1 has a configurable modulus for mm:ss style timers. It supports saturate or wrap on overflow, and holds a high-score register with a new-record pulse. It sits between the collision/timer event logic and the digit-to-bitmap display path; one instance serves as the score, another as the countdown timer.

Parameters:
NUM_DIGITS, 4, number of BCD digits in count (2..8).
DIGIT1_MOD, 10, modulus of digit 1 (second digit from LSB); 6 gives mm:ss; legal range 2..10.
SATURATE, 1, 1 = clamp at max on overflow, 0 = wrap.
INIT_VALUE, 0, packed BCD value loaded by resetN and clear.

Ports:
clk  in  1  system clock.
resetN  in  1  async active-low reset.
clear  in  1  sync; reload count with INIT_VALUE, clear overflow.
freezeN  in  1  sync active-low hold; 0 blocks add/dec.
add_valid  in  1  one-cycle request to add add_value.
add_value  in  4*NUM_DIGITS  packed BCD addend, digit 0 in [3:0].
dec_valid  in  1  one-cycle request to subtract 1.
commit  in  1  one-cycle pulse: compare count against high_score.
count  out  4*NUM_DIGITS  current packed BCD value.
zero  out  1  combinational, count == 0.
overflow  out  1  sticky; set on carry out of top digit.
high_score  out  4*NUM_DIGITS  best committed value.
new_record  out  1  one-cycle pulse when high_score updated.
bad_input  out  1  one-cycle pulse when add_value rejected.

Behaviour:
- Reset (resetN=0, async): count=INIT_VALUE, high_score=0, overflow=0, new_record=0, bad_input=0.
- Latency: every request is sampled on a clk edge and visible on count after that same edge. Back-to-back requests are accepted every cycle.
- Priority per cycle: clear > freezeN=0 > add_valid > dec_valid.
  - add_valid and dec_valid together: add applied, dec dropped.
  - clear with add/dec: count=INIT_VALUE, requests dropped.
- Digit moduli: all digits are mod 10 except digit 1, which is mod DIGIT1_MOD. Max value has every digit at 9, except digit 1 at DIGIT1_MOD-1.
- Add: ripple BCD add digit by digit.
  - Per digit: sum = a + b + cin; if sum >= mod then digit = sum-mod and cout = 1, else digit = sum and cout = 0.
  - A carry out of the top digit sets overflow. SATURATE=1 loads max value; SATURATE=0 keeps the wrapped digits.
- Input check: if any add_value digit > 9, or digit 1 >= DIGIT1_MOD, the add is ignored (count unchanged) and bad_input pulses 1 cycle. Also checked while frozen; bad_input still pulses.
- Decrement: digit 0 minus 1 with borrow ripple.
  - A borrowing digit reloads mod-1 (digit 1 reloads DIGIT1_MOD-1).
  - At count==0, dec leaves count at 0; no underflow flag, no wrap.
- overflow: sticky until clear or resetN; not cleared by a later wrap.
- High score: on commit, if count > high_score (unsigned compare of packed BCD, valid because digits are valid), high_score<=count and new_record=1 next cycle. Otherwise no change.
  - Equal values do not update.
  - commit uses the pre-update count when it coincides with add/dec/clear.
  - freezeN does not block commit.
  - clear does not touch high_score.
- new_record and bad_input: single-cycle pulses, 0 otherwise.
- Reset mid-operation: any pending pulse is dropped and outputs take reset values immediately.

Test Plan:
1. Reset, then 12 cycles of add_valid with add_value=0x0001 -> count=0x0012, zero=0, overflow=0.
2. count=0x0095, add 0x0007 -> count=0x0102 next edge (two-digit carry ripple).
3. count=0x9990, add 0x0020:
   - SATURATE=1 -> count=0x9999, overflow=1.
   - SATURATE=0 -> count=0x0010, overflow=1.
   - Then clear -> count=0x0000, overflow=0.
4. Timer instance NUM_DIGITS=3, DIGIT1_MOD=6, INIT_VALUE=0x100:
   - One dec -> 0x059.
   - 59 more decs -> 0x000, zero=1.
   - Further dec -> stays 0x000.
5. freezeN=0 with add_valid for 5 cycles -> count unchanged. Release, then add_valid=dec_valid=1 with add_value=0x0003 from 0x0010 -> 0x0013.
6. Bad input and high score:
   - add_value=0x000A -> count unchanged, bad_input pulse.
   - count=0x0120, high_score=0x0100, commit -> high_score=0x0120, new_record 1 cycle.
   - Second commit -> no pulse.

Source files
------------

// File: rtl/bcd_score_counter_n.sv
// Multi-digit packed-BCD counter with add/decrement, overflow handling and a high-score register.
// Digit 1 has a configurable modulus so one instance can run an mm:ss countdown.
module bcd_score_counter_n #(
    parameter int unsigned              NUM_DIGITS = 4,
    parameter int unsigned              DIGIT1_MOD = 10,
    parameter int unsigned              SATURATE   = 1,
    parameter logic [4*NUM_DIGITS-1:0]  INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    clear,
    input  logic                    freezeN,
    input  logic                    add_valid,
    input  logic [4*NUM_DIGITS-1:0] add_value,
    input  logic                    dec_valid,
    input  logic                    commit,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    zero,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] high_score,
    output logic                    new_record,
    output logic                    bad_input
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    function automatic logic [4:0] digit_mod(input int unsigned idx);
        return (idx == 1) ? 5'(DIGIT1_MOD) : 5'd10;
    endfunction

    function automatic logic [W-1:0] max_value();
        logic [W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            v[4*i +: 4] = 4'(digit_mod(i) - 5'd1);
        return v;
    endfunction

    localparam logic [W-1:0] MAX_VALUE = max_value();

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] high_q, high_d;
    logic         ovf_q, ovf_d;
    logic         nr_q, nr_d;
    logic         bad_q, bad_d;

    logic [W-1:0] sum_val;
    logic         add_carry;
    logic         add_ok;
    logic [W-1:0] dec_val;
    logic         is_zero;

    assign is_zero = (count_q == '0);

    // Ripple BCD add; the same per-digit modulus test doubles as the addend range check.
    always_comb begin
        logic       c;
        logic [4:0] s;
        sum_val = '0;
        add_ok  = 1'b1;
        c       = 1'b0;
        s       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            s = {1'b0, count_q[4*i +: 4]} + {1'b0, add_value[4*i +: 4]} + {4'd0, c};
            if (s >= digit_mod(i)) begin
                sum_val[4*i +: 4] = 4'(s - digit_mod(i));
                c = 1'b1;
            end else begin
                sum_val[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
            if ({1'b0, add_value[4*i +: 4]} >= digit_mod(i))
                add_ok = 1'b0;
        end
        add_carry = c;
    end

    always_comb begin
        logic b;
        dec_val = count_q;
        b       = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (dec_val[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = MAX_VALUE[4*i +: 4];
                end else begin
                    dec_val[4*i +: 4] = dec_val[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        bad_d   = 1'b0;
        if (clear) begin
            count_d = INIT_VALUE;
            ovf_d   = 1'b0;
        end else if (!freezeN) begin
            bad_d = add_valid & ~add_ok;
        end else if (add_valid) begin
            if (!add_ok) begin
                bad_d = 1'b1;
            end else begin
                count_d = (add_carry && SATURATE != 0) ? MAX_VALUE : sum_val;
                if (add_carry)
                    ovf_d = 1'b1;
            end
        end else if (dec_valid && !is_zero) begin
            count_d = dec_val;
        end
    end

    // Commit compares the pre-update count and ignores freeze/clear.
    always_comb begin
        high_d = high_q;
        nr_d   = 1'b0;
        if (commit && (count_q > high_q)) begin
            high_d = count_q;
            nr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= INIT_VALUE;
            high_q  <= '0;
            ovf_q   <= 1'b0;
            nr_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            high_q  <= high_d;
            ovf_q   <= ovf_d;
            nr_q    <= nr_d;
            bad_q   <= bad_d;
        end
    end

    assign count      = count_q;
    assign zero       = is_zero;
    assign overflow   = ovf_q;
    assign high_score = high_q;
    assign new_record = nr_q;
    assign bad_input  = bad_q;

endmodule

// File: tb/tb_bcd_score_counter_n.sv
// Directed-vector bench: two 4-digit score instances (saturate / wrap) sharing stimulus,
// plus a 3-digit mm:ss style countdown instance.
module tb_bcd_score_counter_n;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    logic        clear, freezeN, add_valid, dec_valid, commit;
    logic [15:0] add_value;
    logic        t_clear, t_add_valid, t_dec_valid;
    logic [11:0] t_add_value;

    logic [15:0] a_count, a_hs, b_count, b_hs;
    logic        a_zero, a_ovf, a_nr, a_bad, b_zero, b_ovf, b_nr, b_bad;
    logic [11:0] t_count, t_hs;
    logic        t_zero, t_ovf, t_nr, t_bad;

    int vectors = 0;
    int miscompares = 0;

    bcd_score_counter_n #(.NUM_DIGITS(4), .DIGIT1_MOD(10), .SATURATE(1), .INIT_VALUE(16'h0000)) u_sat (
        .clk(clk), .resetN(resetN), .clear(clear), .freezeN(freezeN),
        .add_valid(add_valid), .add_value(add_value), .dec_valid(dec_valid), .commit(commit),
        .count(a_count), .zero(a_zero), .overflow(a_ovf), .high_score(a_hs),
        .new_record(a_nr), .bad_input(a_bad));

    bcd_score_counter_n #(.NUM_DIGITS(4), .DIGIT1_MOD(10), .SATURATE(0), .INIT_VALUE(16'h0000)) u_wrap (
        .clk(clk), .resetN(resetN), .clear(clear), .freezeN(freezeN),
        .add_valid(add_valid), .add_value(add_value), .dec_valid(dec_valid), .commit(commit),
        .count(b_count), .zero(b_zero), .overflow(b_ovf), .high_score(b_hs),
        .new_record(b_nr), .bad_input(b_bad));

    bcd_score_counter_n #(.NUM_DIGITS(3), .DIGIT1_MOD(6), .SATURATE(1), .INIT_VALUE(12'h100)) u_timer (
        .clk(clk), .resetN(resetN), .clear(t_clear), .freezeN(1'b1),
        .add_valid(t_add_valid), .add_value(t_add_value), .dec_valid(t_dec_valid), .commit(1'b0),
        .count(t_count), .zero(t_zero), .overflow(t_ovf), .high_score(t_hs),
        .new_record(t_nr), .bad_input(t_bad));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, sample 1 time unit later, then drop the one-cycle requests.
    task automatic step();
        @(posedge clk);
        #1;
        clear = 1'b0; add_valid = 1'b0; dec_valid = 1'b0; commit = 1'b0;
        t_clear = 1'b0; t_add_valid = 1'b0; t_dec_valid = 1'b0;
    endtask

    task automatic add(input logic [15:0] v);
        add_value = v; add_valid = 1'b1; step();
    endtask

    task automatic tadd(input logic [11:0] v);
        t_add_value = v; t_add_valid = 1'b1; step();
    endtask

    initial begin
        resetN = 1'b0; clear = 1'b0; freezeN = 1'b1; add_valid = 1'b0; dec_valid = 1'b0;
        commit = 1'b0; add_value = '0; t_clear = 1'b0; t_add_valid = 1'b0;
        t_dec_valid = 1'b0; t_add_value = '0;
        #12;
        check("rst_count",  32'(a_count), 32'h0);
        check("rst_zero",   32'(a_zero), 32'h1);
        check("rst_ovf",    32'(a_ovf), 32'h0);
        check("rst_hs",     32'(a_hs), 32'h0);
        check("rst_nr",     32'(a_nr), 32'h0);
        check("rst_bad",    32'(a_bad), 32'h0);
        check("rst_tcount", 32'(t_count), 32'h100);
        check("rst_tzero",  32'(t_zero), 32'h0);
        resetN = 1'b1;

        for (int i = 0; i < 12; i++) add(16'h0001);
        check("inc12_sat",  32'(a_count), 32'h0012);
        check("inc12_wrap", 32'(b_count), 32'h0012);
        check("inc12_zero", 32'(a_zero), 32'h0);
        check("inc12_ovf",  32'(a_ovf), 32'h0);

        clear = 1'b1; step();
        check("clear0", 32'(a_count), 32'h0);
        add(16'h0095);
        add(16'h0007);
        check("ripple_carry", 32'(a_count), 32'h0102);
        dec_valid = 1'b1; step();
        check("dec_simple", 32'(a_count), 32'h0101);
        clear = 1'b1; step();
        add(16'h0100);
        dec_valid = 1'b1; step();
        check("dec_borrow", 32'(a_count), 32'h0099);

        clear = 1'b1; step();
        add(16'h9990);
        check("pre_ovf", 32'(a_count), 32'h9990);
        add(16'h0020);
        check("sat_count",  32'(a_count), 32'h9999);
        check("sat_ovf",    32'(a_ovf), 32'h1);
        check("wrap_count", 32'(b_count), 32'h0010);
        check("wrap_ovf",   32'(b_ovf), 32'h1);
        add(16'h9990);
        check("sat_hold",    32'(a_count), 32'h9999);
        check("wrap_again",  32'(b_count), 32'h0000);
        check("wrap_sticky", 32'(b_ovf), 32'h1);
        clear = 1'b1; step();
        check("clr_count", 32'(a_count), 32'h0);
        check("clr_ovf",   32'(a_ovf), 32'h0);
        check("clr_ovf_b", 32'(b_ovf), 32'h0);
        dec_valid = 1'b1; step();
        check("dec_at_zero", 32'(a_count), 32'h0);
        check("zero_flag",   32'(a_zero), 32'h1);

        add(16'h0010);
        freezeN = 1'b0;
        for (int i = 0; i < 5; i++) add(16'h0001);
        check("frozen_count", 32'(a_count), 32'h0010);
        add(16'h000A);
        check("frozen_bad",  32'(a_bad), 32'h1);
        check("frozen_cnt2", 32'(a_count), 32'h0010);
        freezeN = 1'b1;
        add_value = 16'h0003; add_valid = 1'b1; dec_valid = 1'b1; step();
        check("add_beats_dec", 32'(a_count), 32'h0013);
        check("bad_cleared",   32'(a_bad), 32'h0);

        add(16'h000A);
        check("bad_d0_count", 32'(a_count), 32'h0013);
        check("bad_d0_pulse", 32'(a_bad), 32'h1);
        step();
        check("bad_pulse_end", 32'(a_bad), 32'h0);
        add(16'h00A0);
        check("bad_d1_pulse", 32'(a_bad), 32'h1);
        check("bad_d1_count", 32'(a_count), 32'h0013);

        clear = 1'b1; step();
        add(16'h0100);
        commit = 1'b1; step();
        check("hs_first", 32'(a_hs), 32'h0100);
        check("nr_first", 32'(a_nr), 32'h1);
        add(16'h0020);
        check("nr_end",  32'(a_nr), 32'h0);
        check("cnt_120", 32'(a_count), 32'h0120);
        commit = 1'b1; step();
        check("hs_120", 32'(a_hs), 32'h0120);
        check("nr_120", 32'(a_nr), 32'h1);
        commit = 1'b1; step();
        check("hs_equal", 32'(a_hs), 32'h0120);
        check("nr_equal", 32'(a_nr), 32'h0);
        clear = 1'b1; step();
        commit = 1'b1; step();
        check("hs_lower", 32'(a_hs), 32'h0120);
        check("nr_lower", 32'(a_nr), 32'h0);
        add(16'h0200);
        commit = 1'b1; clear = 1'b1; step();
        check("commit_clear_cnt", 32'(a_count), 32'h0);
        check("commit_clear_hs",  32'(a_hs), 32'h0200);
        check("commit_clear_nr",  32'(a_nr), 32'h1);

        t_dec_valid = 1'b1; step();
        check("t_dec1", 32'(t_count), 32'h059);
        for (int i = 0; i < 59; i++) begin
            t_dec_valid = 1'b1; step();
        end
        check("t_to_zero", 32'(t_count), 32'h000);
        check("t_zero",    32'(t_zero), 32'h1);
        t_dec_valid = 1'b1; step();
        check("t_stay0", 32'(t_count), 32'h000);
        tadd(12'h060);
        check("t_bad_d1",  32'(t_bad), 32'h1);
        check("t_bad_cnt", 32'(t_count), 32'h000);
        tadd(12'h059);
        tadd(12'h001);
        check("t_mod6_carry", 32'(t_count), 32'h100);
        tadd(12'h059);
        tadd(12'h900);
        check("t_sat_max", 32'(t_count), 32'h959);
        check("t_ovf",     32'(t_ovf), 32'h1);

        add(16'h0300);
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        check("pre_rst_nr", 32'(a_nr), 32'h1);
        resetN = 1'b0;
        #1;
        check("mid_rst_nr",    32'(a_nr), 32'h0);
        check("mid_rst_cnt",   32'(a_count), 32'h0);
        check("mid_rst_hs",    32'(a_hs), 32'h0);
        check("mid_rst_tcnt",  32'(t_count), 32'h100);
        check("mid_rst_tovf",  32'(t_ovf), 32'h0);
        resetN = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
